// File: rtl/neo_frame_loader.sv
// Shadow frame buffer with commit-time snapshot. Feeds the active frame to the NeoPixel
// strand controller one colour component at a time, then sends, drains and waits out the latch.
`timescale 1ns/1ps
module neo_frame_loader #(
    parameter int NUM_PIXELS = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [2:0]  wr_pixel,
    input  logic [23:0] wr_grb,
    input  logic        commit,
    output logic        busy,
    output logic        pending,
    output logic        frame_done,
    output logic        load_color,
    output logic [1:0]  color_index,
    output logic [2:0]  pixel_index,
    output logic [7:0]  color_level,
    output logic        send_it,
    input  logic        ready_to_load,
    input  logic        ready_to_send
);
    typedef enum logic [2:0] {IDLE, LOAD, SEND, DRAIN, LATCH} state_t;
    localparam logic [2:0] LAST_PIX = 3'(NUM_PIXELS - 1);

    state_t      state_q, state_d;
    logic [23:0] shadow_q [NUM_PIXELS];
    logic [23:0] shadow_d [NUM_PIXELS];
    logic [23:0] active_q [NUM_PIXELS];
    logic [23:0] active_d [NUM_PIXELS];
    logic [2:0]  pix_q, pix_d;
    logic [1:0]  comp_q, comp_d;
    logic        pending_q, pending_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
    logic        load_color_q, load_color_d;
    logic        send_it_q, send_it_d;
    logic [1:0]  color_index_q, color_index_d;
    logic [2:0]  pixel_index_q, pixel_index_d;
    logic [7:0]  color_level_q, color_level_d;

    // Component order on the wire is R, B, G.
    function automatic logic [7:0] component(input logic [23:0] grb, input logic [1:0] comp);
        case (comp)
            2'd0:    component = grb[15:8];
            2'd1:    component = grb[7:0];
            default: component = grb[23:16];
        endcase
    endfunction

    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < NUM_PIXELS; i++) begin
            if (wr_en && wr_pixel == 3'(i)) shadow_d[i] = wr_grb;
        end

        state_d       = state_q;
        active_d      = active_q;
        pix_d         = pix_q;
        comp_d        = comp_q;
        pending_d     = pending_q;
        frame_done_d  = 1'b0;
        load_color_d  = 1'b0;
        send_it_d     = 1'b0;
        color_index_d = 2'd0;
        pixel_index_d = 3'd0;
        color_level_d = 8'd0;

        if (commit && state_q != IDLE) pending_d = 1'b1;

        // Snapshots take shadow_d so a same-cycle write is included.
        case (state_q)
            IDLE: begin
                if (commit) begin
                    active_d = shadow_d;
                    pix_d    = 3'd0;
                    comp_d   = 2'd0;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (ready_to_load) begin
                    load_color_d  = 1'b1;
                    pixel_index_d = pix_q;
                    color_index_d = comp_q;
                    color_level_d = component(active_q[pix_q], comp_q);
                    if (comp_q == 2'd2) begin
                        comp_d = 2'd0;
                        if (pix_q == LAST_PIX) state_d = SEND;
                        else                   pix_d = pix_q + 3'd1;
                    end else begin
                        comp_d = comp_q + 2'd1;
                    end
                end
            end
            SEND: begin
                if (ready_to_send) begin
                    send_it_d = 1'b1;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                if (!ready_to_send) state_d = LATCH;
            end
            LATCH: begin
                if (ready_to_send) begin
                    frame_done_d = 1'b1;
                    if (pending_q || commit) begin
                        pending_d = 1'b0;
                        active_d  = shadow_d;
                        pix_d     = 3'd0;
                        comp_d    = 2'd0;
                        state_d   = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            pix_q         <= 3'd0;
            comp_q        <= 2'd0;
            pending_q     <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            load_color_q  <= 1'b0;
            send_it_q     <= 1'b0;
            color_index_q <= 2'd0;
            pixel_index_q <= 3'd0;
            color_level_q <= 8'd0;
            for (int i = 0; i < NUM_PIXELS; i++) shadow_q[i] <= 24'd0;
        end else begin
            state_q       <= state_d;
            pix_q         <= pix_d;
            comp_q        <= comp_d;
            pending_q     <= pending_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            load_color_q  <= load_color_d;
            send_it_q     <= send_it_d;
            color_index_q <= color_index_d;
            pixel_index_q <= pixel_index_d;
            color_level_q <= color_level_d;
            shadow_q      <= shadow_d;
        end
    end

    // The active frame is only read after a snapshot, so it needs no reset.
    always_ff @(posedge clock) begin
        active_q <= active_d;
    end

    assign busy        = busy_q;
    assign pending     = pending_q;
    assign frame_done  = frame_done_q;
    assign load_color  = load_color_q;
    assign send_it     = send_it_q;
    assign color_index = color_index_q;
    assign pixel_index = pixel_index_q;
    assign color_level = color_level_q;
endmodule

// File: tb/tb_neo_frame_loader.sv
// Bench for neo_frame_loader: table vectors, hand-written corner sequences and random frames,
// all checked against a frame-level model (shadow array + expected load list).
`timescale 1ns/1ps
module tb_neo_frame_loader;
    localparam int N     = 5;
    localparam int LIMIT = 6000;

    logic        clock = 1'b0;
    logic        reset, wr_en, commit, ready_to_load, ready_to_send;
    logic [2:0]  wr_pixel;
    logic [23:0] wr_grb;
    logic        busy, pending, frame_done, load_color, send_it;
    logic [1:0]  color_index;
    logic [2:0]  pixel_index;
    logic [7:0]  color_level;

    int checks = 0;
    int errors = 0;

    logic [23:0] model_shadow [N];
    logic [23:0] exp_frame [N];
    int          obs_level [3*N];

    typedef struct {
        logic [2:0]  wr_pixel;
        logic [23:0] wr_grb;
        bit          bypass;
        int          drain;
        int          chk_pix;
        int          exp_r;
        int          exp_b;
        int          exp_g;
    } vec_t;
    vec_t vecs [5];

    always #10 clock = ~clock;

    neo_frame_loader #(.NUM_PIXELS(N)) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_pixel(wr_pixel), .wr_grb(wr_grb),
        .commit(commit), .busy(busy), .pending(pending), .frame_done(frame_done),
        .load_color(load_color), .color_index(color_index), .pixel_index(pixel_index),
        .color_level(color_level), .send_it(send_it),
        .ready_to_load(ready_to_load), .ready_to_send(ready_to_send)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_level(input logic [23:0] grb, input int comp);
        int shift;
        shift = (comp == 0) ? 8 : (comp == 1) ? 0 : 16;
        return int'((grb >> shift) & 24'hFF);
    endfunction

    task automatic model_write(input int p, input logic [23:0] v);
        if (p < N) model_shadow[p] = v;
    endtask

    task automatic snap();
        for (int i = 0; i < N; i++) exp_frame[i] = model_shadow[i];
    endtask

    task automatic check_all_zero(input string tag);
        int acc;
        acc = int'(busy) + int'(pending) + int'(frame_done) + int'(load_color) + int'(send_it)
            + int'(color_index) + int'(pixel_index) + int'(color_level);
        check(tag, acc, 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic idle_check(input int n);
        int ev = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (load_color || send_it || frame_done || busy) ev++;
        end
        check("idle_quiet", ev, 0);
    endtask

    // Plays the strand controller for one frame and checks every load against exp_frame.
    task automatic run_frame(input int first_cyc, input int stall_at, input int stall_len,
                             input int drain_len, input int send_gate, input bit queue_cmds);
        int cyc = 0, nloads = 0, nsend = 0, ndone = 0;
        int stall_cnt = 0, gate_cnt = 0, drain_cnt = 0;
        int last_load = -1, send_rise = -1, rise_cyc = -1;
        int exp_cyc, comp, ds;
        ready_to_load = 1'b1;
        ready_to_send = (send_gate == 0);
        while (ndone == 0 && cyc < LIMIT) begin
            @(negedge clock);
            cyc++;
            commit = 1'b0;
            wr_en  = 1'b0;
            if (cyc == 1) check("busy_in_frame", int'(busy), 1);
            if (load_color) begin
                comp    = nloads % 3;
                exp_cyc = first_cyc + nloads
                        + ((stall_at > 0 && stall_len > 0 && nloads >= stall_at) ? stall_len : 0);
                check("load_cycle", cyc, exp_cyc);
                check("load_send_overlap", int'(send_it), 0);
                if (nloads < 3*N) begin
                    check("load_pix", int'(pixel_index), nloads / 3);
                    check("load_idx", int'(color_index), comp);
                    check("load_level", int'(color_level), exp_level(exp_frame[nloads / 3], comp));
                    obs_level[nloads] = int'(color_level);
                end
                nloads++;
                last_load = cyc;
                if (stall_len > 0 && nloads == stall_at) begin
                    ready_to_load = 1'b0;
                    stall_cnt     = stall_len;
                end
            end else if (stall_cnt > 0) begin
                stall_cnt--;
                if (stall_cnt == 0) ready_to_load = 1'b1;
            end
            if (send_it) begin
                nsend++;
                check("send_cycle", cyc, (send_gate > 0) ? send_rise + 1 : last_load + 1);
                ready_to_send = 1'b0;
                drain_cnt     = drain_len;
            end else if (nsend > 0 && drain_cnt > 0) begin
                drain_cnt--;
                ds = drain_len - drain_cnt;
                if (queue_cmds && (ds == 2 || ds == 4 || ds == 6)) commit = 1'b1;
                if (queue_cmds && ds == 8) begin
                    wr_en    = 1'b1;
                    wr_pixel = 3'd4;
                    wr_grb   = 24'hABCDEF;
                    model_write(4, 24'hABCDEF);
                end
                if (drain_cnt == 0) begin
                    ready_to_send = 1'b1;
                    rise_cyc      = cyc;
                    if (queue_cmds) check("pending_queued", int'(pending), 1);
                end
            end else if (nsend == 0 && send_gate > 0 && nloads >= 3*N && !ready_to_send) begin
                gate_cnt++;
                if (gate_cnt == send_gate) begin
                    ready_to_send = 1'b1;
                    send_rise     = cyc;
                end
            end
            if (frame_done) begin
                ndone++;
                check("done_cycle", cyc, rise_cyc + 1);
            end
        end
        check("load_count", nloads, 3*N);
        check("send_count", nsend, 1);
        check("done_count", ndone, 1);
    endtask

    initial begin
        int p, nw, seen, t;
        bit byp;
        logic [23:0] v;

        vecs[0] = '{3'd0, 24'h112233, 1'b0, 2600, 0, 8'h22, 8'h33, 8'h11};
        vecs[1] = '{3'd1, 24'h0000FF, 1'b1, 5,    1, 8'h00, 8'hFF, 8'h00};
        vecs[2] = '{3'd6, 24'hFFFFFF, 1'b0, 5,    0, 8'h22, 8'h33, 8'h11};
        vecs[3] = '{3'd4, 24'hABCDEF, 1'b1, 5,    4, 8'hCD, 8'hEF, 8'hAB};
        vecs[4] = '{3'd7, 24'h123456, 1'b0, 5,    1, 8'h00, 8'hFF, 8'h00};

        reset = 1'b1; wr_en = 1'b0; commit = 1'b0; wr_pixel = 3'd0; wr_grb = 24'd0;
        ready_to_load = 1'b1; ready_to_send = 1'b1;
        for (int i = 0; i < N; i++) model_shadow[i] = 24'd0;
        repeat (3) @(negedge clock);
        check_all_zero("reset_state");
        reset = 1'b0;

        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            wr_en = 1'b1; wr_pixel = vecs[k].wr_pixel; wr_grb = vecs[k].wr_grb;
            model_write(int'(vecs[k].wr_pixel), vecs[k].wr_grb);
            if (vecs[k].bypass) commit = 1'b1;
            else begin
                @(negedge clock);
                wr_en = 1'b0; commit = 1'b1;
            end
            snap();
            run_frame(2, 0, 0, vecs[k].drain, 0, 1'b0);
            check("vec_r", obs_level[vecs[k].chk_pix*3 + 0], vecs[k].exp_r);
            check("vec_b", obs_level[vecs[k].chk_pix*3 + 1], vecs[k].exp_b);
            check("vec_g", obs_level[vecs[k].chk_pix*3 + 2], vecs[k].exp_g);
            if (k == 0) idle_check(10);
        end

        // Stall in the middle of pixel 2.
        @(negedge clock); commit = 1'b1; snap();
        run_frame(2, 7, 5, 5, 0, 1'b0);

        // Send gating: ready_to_send held low for 100 cycles in SEND.
        @(negedge clock); commit = 1'b1; snap();
        run_frame(2, 0, 0, 5, 100, 1'b0);

        // Queued commit: pixel 4 is cleared, then rewritten while the first frame latches.
        @(negedge clock); wr_en = 1'b1; wr_pixel = 3'd4; wr_grb = 24'd0; model_write(4, 24'd0);
        @(negedge clock); wr_en = 1'b0; commit = 1'b1; snap();
        run_frame(2, 0, 0, 12, 0, 1'b1);
        check("q_first_pix4_r", obs_level[12], 0);
        snap();
        run_frame(1, 0, 0, 5, 0, 1'b0);
        check("q_pix4_r", obs_level[12], 8'hCD);
        check("q_pix4_b", obs_level[13], 8'hEF);
        check("q_pix4_g", obs_level[14], 8'hAB);
        check("q_pending_clear", int'(pending), 0);
        idle_check(20);

        // Reset after the 7th load, with a commit queued.
        @(negedge clock); commit = 1'b1; snap();
        ready_to_load = 1'b1; ready_to_send = 1'b1;
        seen = 0; t = 0;
        while (seen < 7 && t < 100) begin
            @(negedge clock);
            t++;
            commit = 1'b0;
            if (load_color) seen++;
            if (t == 4) commit = 1'b1;
        end
        check("rst_mid_seen7", seen, 7);
        check("rst_mid_pending", int'(pending), 1);
        commit = 1'b0;
        reset  = 1'b1;
        @(negedge clock);
        check_all_zero("rst_mid_outputs");
        reset = 1'b0;
        for (int i = 0; i < N; i++) model_shadow[i] = 24'd0;
        @(negedge clock); wr_en = 1'b1; wr_pixel = 3'd0; wr_grb = 24'h5A6B7C;
        model_write(0, 24'h5A6B7C); commit = 1'b1; snap();
        run_frame(2, 0, 0, 5, 0, 1'b0);
        check("rst_restart_r", obs_level[0], 8'h6B);

        // Random frames against the model.
        for (int r = 0; r < 8; r++) begin
            nw  = int'($urandom_range(1, 4));
            byp = 1'($urandom_range(0, 1));
            for (int w = 0; w < nw; w++) begin
                @(negedge clock);
                p = int'($urandom_range(0, 7));
                v = 24'($urandom);
                wr_en = 1'b1; wr_pixel = 3'(p); wr_grb = v;
                model_write(p, v);
                if (w == nw - 1 && byp) commit = 1'b1;
            end
            if (!byp) begin
                @(negedge clock);
                wr_en = 1'b0; commit = 1'b1;
            end
            snap();
            run_frame(2, int'($urandom_range(1, 14)), int'($urandom_range(0, 4)),
                      int'($urandom_range(1, 40)),
                      ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 20)) : 0, 1'b0);
        end
        idle_check(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
